fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory request, 2-entry {pc, instr}
// buffer toward decode, and redirect handling that discards in-flight responses.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        PCSrc,
   input  logic [31:0] PCTarget,
   input  logic        stall,
   output logic [31:0] Instr,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic        instr_valid
);

   typedef enum logic [1:0] {IDLE, BUSY, DROP} state_e;

   state_e      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] hold_addr_q, hold_addr_d;
   logic [31:0] fifo_pc_q    [2];
   logic [31:0] fifo_pc_d    [2];
   logic [31:0] fifo_instr_q [2];
   logic [31:0] fifo_instr_d [2];
   logic        rd_ptr_q, rd_ptr_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic [1:0]  count_q, count_d;
   logic        enq, deq;

   assign instr_valid = (count_q != 2'd0);
   assign deq         = instr_valid & ~stall & ~PCSrc;
   assign enq         = (state_q == BUSY) & imem_ready & ~PCSrc;

   // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      hold_addr_d  = hold_addr_q;
      fifo_pc_d    = fifo_pc_q;
      fifo_instr_d = fifo_instr_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      if (PCSrc) begin
         // Redirect wins: flush, and remember the abandoned address so it stays stable until its response arrives.
         fetch_pc_d = PCTarget & ~32'h3;
         rd_ptr_d   = 1'b0;
         wr_ptr_d   = 1'b0;
         count_d    = 2'd0;
         if (state_q == BUSY && !imem_ready) hold_addr_d = fetch_pc_q;
      end else begin
         if (enq) begin
            fifo_pc_d[wr_ptr_q]    = fetch_pc_q;
            fifo_instr_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d               = ~wr_ptr_q;
            fetch_pc_d             = fetch_pc_q + 32'd4;
         end
         if (deq) rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, enq} - {1'b0, deq};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         fetch_pc_q  <= RESET_PC;
         hold_addr_q <= RESET_PC;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         hold_addr_q <= hold_addr_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
      end
   end

   // NOTE: buffer storage is not reset; count_q alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
   end

   // A request is issued only when its response is sure to find a free slot.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (count_d != 2'd2) state_d = BUSY;
         BUSY: begin
            if (imem_ready)  state_d = (count_d == 2'd2) ? IDLE : BUSY;
            else if (PCSrc)  state_d = DROP;
         end
         DROP: if (imem_ready) state_d = BUSY;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      imem_req  = (state_q != IDLE);
      imem_addr = (state_q == DROP) ? hold_addr_q : fetch_pc_q;
   end

   always_comb begin
      Instr   = instr_valid ? fifo_instr_q[rd_ptr_q] : NOP_INSTR;
      PC      = instr_valid ? fifo_pc_q[rd_ptr_q] : fetch_pc_q;
      PCPlus4 = PC + 32'd4;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall backpressure, redirects during
// wait and response cycles, reset mid-transfer, and PC wrap on a second instance.
module tb_fetch_unit;

   localparam logic [31:0] K   = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, imem_ready, pcsrc, stall, instr_valid;
   logic [31:0] imem_addr, imem_rdata, pc_target, instr, pc, pc_plus4;

   logic        req2, valid2;
   logic        ready2 = 1'b1, pcsrc2 = 1'b0, stall2 = 1'b0;
   logic [31:0] addr2, rdata2, instr2, pc2, pc_plus4_2;
   logic [31:0] target2 = 32'h0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Memory model: each word encodes its own address.
   assign imem_rdata = imem_addr ^ K;
   assign rdata2     = addr2 ^ K;

   fetch_unit dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PCSrc(pcsrc),
      .PCTarget(pc_target), .stall(stall), .Instr(instr), .PC(pc),
      .PCPlus4(pc_plus4), .instr_valid(instr_valid)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
      .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
      .imem_ready(ready2), .imem_rdata(rdata2), .PCSrc(pcsrc2),
      .PCTarget(target2), .stall(stall2), .Instr(instr2), .PC(pc2),
      .PCPlus4(pc_plus4_2), .instr_valid(valid2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; imem_ready = 1'b0; pcsrc = 1'b0; stall = 1'b0; pc_target = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req",    imem_req, 32'h0);
      check("rst_valid",  instr_valid, 32'h0);
      check("rst_instr",  instr, NOP);
      check("rst_pc",     pc, 32'h0);
      check("rst_pc4",    pc_plus4, 32'h4);
      check("rst2_pc",    pc2, 32'hFFFF_FFF8);
      check("rst2_pc4",   pc_plus4_2, 32'hFFFF_FFFC);

      // Streaming with a zero-latency memory
      imem_ready = 1'b1;
      rst = 1'b0;
      step();
      check("first_req",   imem_req, 32'h1);
      check("first_addr",  imem_addr, 32'h0);
      check("first_valid", instr_valid, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("stream_valid", instr_valid, 32'h1);
         check("stream_pc",    pc, 32'(4 * i));
         check("stream_instr", instr, 32'(4 * i) ^ K);
         check("stream_pc4",   pc_plus4, 32'(4 * i + 4));
      end

      // Stall: head PC 0xC frozen, buffer fills, request drops
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_pc",    pc, 32'hC);
         check("stall_instr", instr, 32'hC ^ K);
         check("stall_valid", instr_valid, 32'h1);
         check("stall_req",   imem_req, 32'h0);
      end
      stall = 1'b0;
      step();
      check("resume_pc",   pc, 32'h10);
      check("resume_req",  imem_req, 32'h1);
      check("resume_addr", imem_addr, 32'h14);
      step();
      check("resume_pc2",  pc, 32'h14);
      step();
      check("resume_pc3",  pc, 32'h18);

      // Slow memory, redirect to 0x100 in the second wait cycle
      imem_ready = 1'b0;
      step();
      check("wait1_valid", instr_valid, 32'h0);
      check("wait1_addr",  imem_addr, 32'h1C);
      pcsrc = 1'b1; pc_target = 32'h100;
      step();
      pcsrc = 1'b0;
      check("drop_req",   imem_req, 32'h1);
      check("drop_addr",  imem_addr, 32'h1C);
      check("drop_valid", instr_valid, 32'h0);
      step();
      check("drop_addr2", imem_addr, 32'h1C);
      imem_ready = 1'b1;
      step();
      check("drop_done_valid", instr_valid, 32'h0);
      check("drop_done_addr",  imem_addr, 32'h100);
      step();
      check("redir_valid", instr_valid, 32'h1);
      check("redir_pc",    pc, 32'h100);
      check("redir_instr", instr, 32'h100 ^ K);

      // Redirect to unaligned 0x203 in a response cycle
      pcsrc = 1'b1; pc_target = 32'h203;
      step();
      pcsrc = 1'b0;
      check("same_cyc_valid", instr_valid, 32'h0);
      check("same_cyc_addr",  imem_addr, 32'h200);
      check("same_cyc_req",   imem_req, 32'h1);
      step();
      check("same_cyc_pc",    pc, 32'h200);
      check("same_cyc_instr", instr, 32'h200 ^ K);
      step();
      check("same_cyc_pc2",   pc, 32'h204);

      // Reset while a request is waiting on memory
      imem_ready = 1'b0;
      step();
      check("pre_rst_req", imem_req, 32'h1);
      #1 rst = 1'b1;
      #1;
      check("midrst_req",   imem_req, 32'h0);
      check("midrst_valid", instr_valid, 32'h0);
      check("midrst_instr", instr, NOP);
      check("midrst_pc",    pc, 32'h0);
      imem_ready = 1'b1;
      step();
      check("midrst_req2",  imem_req, 32'h0);
      rst = 1'b0;
      step();
      check("restart_addr",  imem_addr, 32'h0);
      check("restart_valid", instr_valid, 32'h0);
      check("wrap_addr",     addr2, 32'hFFFF_FFF8);
      step();
      check("restart_pc",    pc, 32'h0);
      check("restart_instr", instr, K);
      check("wrap_pc0",      pc2, 32'hFFFF_FFF8);
      check("wrap_instr0",   instr2, 32'hFFFF_FFF8 ^ K);
      step();
      check("wrap_pc1",      pc2, 32'hFFFF_FFFC);
      check("wrap_pc4_1",    pc_plus4_2, 32'h0);
      step();
      check("wrap_pc2",      pc2, 32'h0);
      check("wrap_instr2",   instr2, K);
      check("wrap_valid2",   valid2, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
